lcd_refresh_sequencer: RTL
==========================

Name: lcd_refresh_sequencer

Overview:
Downstream consumer of the 32 x 8 LCD register file. Runs the HD44780 power-up and initialisation sequence over an 8-bit parallel bus. Afterwards it continuously scans register-file addresses 0..31 and writes them to the display: addresses 0..15 go to line 1, addresses 16..31 go to line 2. Its read address drives the register file's read port, and the returned byte drives the LCD data bus.

Parameters:
POWERUP_CYCLES, 1000000, idle cycles after reset before the first command (20 ms at 50 MHz)
ENABLE_CYCLES, 25, cycles lcdE is held high per byte
WAIT_CYCLES, 2500, cycles lcdE is held low after each byte except clear
CLEAR_WAIT_CYCLES, 100000, cycles lcdE is held low after the clear command (0x01)
DELAY_W, 21, delay counter width; must hold the largest of the cycle parameters

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
enable  in  1  1 = keep refreshing frames; 0 = stop at the next frame boundary
rfReadAddr  out  5  read address to the register file
rfData  in  8  register file read data; valid one cycle after rfReadAddr is stable
lcdRs  out  1  0 = command, 1 = character data
lcdRw  out  1  tied 0 (write only)
lcdE  out  1  LCD enable strobe
lcdData  out  8  LCD data bus
initDone  out  1  high once the init sequence has completed; cleared only by reset
frameDone  out  1  one-cycle pulse when the last byte of a frame finishes its wait

Behaviour:
- One clock domain. Reset is asynchronous and active-low: resetN low forces the state immediately; release is sampled on the clk rising edge.
- Reset values:
  - State POWERUP, delay counter 0, char index 0.
  - rfReadAddr=0, lcdRs=0, lcdRw=0, lcdE=0, lcdData=0x00, initDone=0, frameDone=0.
- Reset mid-operation (including with lcdE high) aborts everything. The sequencer restarts from POWERUP with the full wait.
- Byte transfer is a shared sub-sequence; each byte takes 1 + ENABLE_CYCLES + wait cycles:
  - SETUP, 1 cycle: lcdRs and lcdData are driven, lcdE=0.
  - PULSE, ENABLE_CYCLES cycles: lcdE=1.
  - HOLD: lcdE=0 for WAIT_CYCLES, or CLEAR_WAIT_CYCLES when the byte is command 0x01.
  - lcdRs and lcdData stay stable from SETUP through the end of HOLD.
- State sequence:
  - POWERUP: counts POWERUP_CYCLES, then goes to INIT.
  - INIT: four command bytes (lcdRs=0) in order: 0x38 (8-bit, 2-line, 5x8), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear). initDone is set in the cycle after the clear HOLD ends.
  - IDLE: if enable=1, go to LINE1; otherwise remain in IDLE.
  - LINE1: command 0x80 (DDRAM address 0x00), then CHARS with index 0..15.
  - LINE2: command 0xC0 (DDRAM address 0x40), then CHARS with index 16..31.
  - CHARS: per character, a FETCH cycle drives rfReadAddr=index. SETUP then latches rfData into lcdData with lcdRs=1.
- Frame length is 34 bytes. frameDone pulses in the final cycle of the 34th HOLD.
- At the frame boundary: if enable=1, go directly to LINE1 with no idle gap; if enable=0, go to IDLE.
- Deasserting enable mid-frame has no effect until the frame completes. enable is ignored during POWERUP and INIT.
- The 5-bit char index wraps from 31 to 0 at the end of each frame.
- rfReadAddr holds its last value between fetches.
- Delay counter:
  - Loads 0 on entry to each timed state.
  - Terminal count is parameter-1.
  - A parameter value of 1 gives a single cycle.

Optional Feature:
LCD_CURSOR_BLINK_EN:
- Defined: the second init command is 0x0F (display on, cursor on, blink on).
- Undefined: the second init command is 0x0C.
- No other behaviour changes.

Test Plan:
Bench parameters for all scenarios: POWERUP_CYCLES=10, ENABLE_CYCLES=2, WAIT_CYCLES=4, CLEAR_WAIT_CYCLES=8.
1. Release reset, enable=0 -> lcdE first rises 11 cycles after release. Bytes 0x38, 0x0C, 0x06 each occur at a 7-cycle period. 0x01 takes 11 cycles. initDone rises in the cycle after the clear HOLD ends. No further lcdE activity.
2. Register file preloaded with address i -> 0x41+i, then enable=1 -> one frame captures 0x80, 0x41..0x50, 0xC0, 0x51..0x60. lcdRs is 0 only on the two commands. frameDone pulses exactly once.
3. enable held 1 -> the second frame's 0x80 SETUP follows the cycle after frameDone. rfReadAddr wraps 31 to 0.
4. Drop enable at character index 5 -> the frame completes all 34 bytes, then the block idles with lcdE=0. Re-raising enable restarts at 0x80.
5. Assert resetN=0 during a PULSE -> lcdE=0 and lcdData=0x00 immediately. initDone=0. After release, the full POWERUP and INIT sequence repeats.
6. With LCD_CURSOR_BLINK_EN defined -> the second init byte is 0x0F. All other bytes and timing are unchanged.

Source files
------------

// File: rtl/lcd_refresh_sequencer.sv
// lcd_refresh_sequencer
// Drives an HD44780-style LCD over an 8-bit parallel bus. After reset it waits
// out the power-up delay and sends the four init commands. It then scans
// register-file addresses 0..31 into display lines 1 and 2.
// Optional build macro: LCD_CURSOR_BLINK_EN. When defined, the display-on
// init command also turns the cursor and blink on (0x0F instead of 0x0C).
// Read-port timing: rfReadAddr is registered and becomes valid at the start of
// the FETCH cycle. rfData is sampled at the end of that cycle, so it is on the
// LCD bus for the whole SETUP cycle.
module lcd_refresh_sequencer #(
   parameter int POWERUP_CYCLES    = 1000000,
   parameter int ENABLE_CYCLES     = 25,
   parameter int WAIT_CYCLES       = 2500,
   parameter int CLEAR_WAIT_CYCLES = 100000,
   parameter int DELAY_W           = 21
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       enable,
   output logic [4:0] rfReadAddr,
   input  logic [7:0] rfData,
   output logic       lcdRs,
   output logic       lcdRw,
   output logic       lcdE,
   output logic [7:0] lcdData,
   output logic       initDone,
   output logic       frameDone
);

`ifdef LCD_CURSOR_BLINK_EN
   localparam logic [7:0] DISPLAY_CMD = 8'h0F;
`else
   localparam logic [7:0] DISPLAY_CMD = 8'h0C;
`endif

   localparam logic [7:0] LINE1_CMD = 8'h80;
   localparam logic [7:0] LINE2_CMD = 8'hC0;
   localparam logic [7:0] CLEAR_CMD = 8'h01;

   // Terminal counts: a timed state with parameter N lasts counts 0..N-1.
   localparam logic [DELAY_W-1:0] PWR_LAST   = DELAY_W'(POWERUP_CYCLES - 1);
   localparam logic [DELAY_W-1:0] EN_LAST    = DELAY_W'(ENABLE_CYCLES - 1);
   localparam logic [DELAY_W-1:0] WAIT_LAST  = DELAY_W'(WAIT_CYCLES - 1);
   localparam logic [DELAY_W-1:0] CLEAR_LAST = DELAY_W'(CLEAR_WAIT_CYCLES - 1);
   // Count value one cycle before the last HOLD cycle. Used to register frameDone early.
   localparam logic [DELAY_W-1:0] WAIT_PRE   = (WAIT_CYCLES >= 2) ? DELAY_W'(WAIT_CYCLES - 2) : '0;
   localparam logic [DELAY_W-1:0] CNT_ONE    = DELAY_W'(1);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_IDLE,
      ST_FETCH,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD
   } state_t;

   state_t             state;
   logic [DELAY_W-1:0] delay_cnt;
   logic [4:0]         char_idx;
   logic [1:0]         init_idx;
   logic               in_frame;   // 0 while the init commands are being sent
   logic               cmd_byte;   // current byte is a command, not a character

   logic is_clear;
   logic hold_last;
   logic last_byte;

   // Init command table, indexed by position in the init sequence.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = DISPLAY_CMD;
         2'd2:    init_cmd = 8'h06;
         default: init_cmd = CLEAR_CMD;
      endcase
   endfunction

   assign is_clear  = !lcdRs && (lcdData == CLEAR_CMD);
   assign hold_last = is_clear ? (delay_cnt == CLEAR_LAST) : (delay_cnt == WAIT_LAST);
   assign last_byte = in_frame && !cmd_byte && (char_idx == 5'd31);
   assign lcdRw     = 1'b0;

   // Sequencer FSM: the power-up wait, the shared byte sub-sequence, and frame scanning.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= ST_POWERUP;
         delay_cnt  <= '0;
         char_idx   <= '0;
         init_idx   <= '0;
         in_frame   <= 1'b0;
         cmd_byte   <= 1'b0;
         rfReadAddr <= '0;
         lcdRs      <= 1'b0;
         lcdE       <= 1'b0;
         lcdData    <= '0;
         initDone   <= 1'b0;
         frameDone  <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         case (state)
            ST_POWERUP: begin
               if (delay_cnt == PWR_LAST) begin
                  delay_cnt <= '0;
                  init_idx  <= 2'd0;
                  cmd_byte  <= 1'b1;
                  lcdRs     <= 1'b0;
                  lcdData   <= init_cmd(2'd0);
                  state     <= ST_SETUP;
               end else begin
                  delay_cnt <= delay_cnt + CNT_ONE;
               end
            end

            ST_IDLE: begin
               if (enable) begin
                  in_frame <= 1'b1;
                  cmd_byte <= 1'b1;
                  char_idx <= '0;
                  lcdRs    <= 1'b0;
                  lcdData  <= LINE1_CMD;
                  state    <= ST_SETUP;
               end
            end

            ST_FETCH: begin
               // rfReadAddr has been stable for this cycle, so rfData is valid.
               lcdRs   <= 1'b1;
               lcdData <= rfData;
               state   <= ST_SETUP;
            end

            ST_SETUP: begin
               delay_cnt <= '0;
               lcdE      <= 1'b1;
               state     <= ST_PULSE;
            end

            ST_PULSE: begin
               if (delay_cnt == EN_LAST) begin
                  delay_cnt <= '0;
                  lcdE      <= 1'b0;
                  state     <= ST_HOLD;
                  if (last_byte && (WAIT_CYCLES == 1))
                     frameDone <= 1'b1;
               end else begin
                  delay_cnt <= delay_cnt + CNT_ONE;
               end
            end

            ST_HOLD: begin
               if (hold_last) begin
                  delay_cnt <= '0;
                  if (!in_frame) begin
                     if (init_idx == 2'd3) begin
                        initDone <= 1'b1;
                        state    <= ST_IDLE;
                     end else begin
                        init_idx <= init_idx + 2'd1;
                        lcdData  <= init_cmd(init_idx + 2'd1);
                        state    <= ST_SETUP;
                     end
                  end else if (cmd_byte) begin
                     // A line-address command is always followed by that line's first character.
                     cmd_byte   <= 1'b0;
                     rfReadAddr <= char_idx;
                     state      <= ST_FETCH;
                  end else if (char_idx == 5'd15) begin
                     char_idx <= 5'd16;
                     cmd_byte <= 1'b1;
                     lcdRs    <= 1'b0;
                     lcdData  <= LINE2_CMD;
                     state    <= ST_SETUP;
                  end else if (char_idx == 5'd31) begin
                     // Frame boundary: enable is only looked at here.
                     char_idx <= '0;
                     if (enable) begin
                        cmd_byte <= 1'b1;
                        lcdRs    <= 1'b0;
                        lcdData  <= LINE1_CMD;
                        state    <= ST_SETUP;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     char_idx   <= char_idx + 5'd1;
                     rfReadAddr <= char_idx + 5'd1;
                     state      <= ST_FETCH;
                  end
               end else begin
                  delay_cnt <= delay_cnt + CNT_ONE;
                  if (last_byte && (WAIT_CYCLES >= 2) && (delay_cnt == WAIT_PRE))
                     frameDone <= 1'b1;
               end
            end

            default: begin
               state <= ST_POWERUP;
            end
         endcase
      end
   end

endmodule
